// File: rtl/seq_bit_scanner_pkg.sv
// Shared constants for the sequential bit scanner: scan-mode encodings and FSM states.
package seq_bit_scanner_pkg;

  localparam logic [1:0] SCAN_CLZ = 2'b00;
  localparam logic [1:0] SCAN_CLO = 2'b01;
  localparam logic [1:0] SCAN_CTZ = 2'b10;
  localparam logic [1:0] SCAN_CTO = 2'b11;

  // LOAD is the edge that forms the work word from the captured operand.
  localparam logic [1:0] SCAN_IDLE = 2'b00;
  localparam logic [1:0] SCAN_LOAD = 2'b01;
  localparam logic [1:0] SCAN_RUN  = 2'b10;
  localparam logic [1:0] SCAN_DONE = 2'b11;

endpackage

// File: rtl/seq_bit_scanner.sv
// Multi-cycle CLZ/CLO/CTZ/CTO scanner.
// Examines one bit per cycle and returns the count plus the operand shifted by that count.
module seq_bit_scanner
  import seq_bit_scanner_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       scan_op,
  input  logic [WIDTH-1:0] operand,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] normalized
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WIDTH);

  logic [1:0]       state;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] opnd_q;
  logic [WIDTH-1:0] work;
  logic [CNT_W-1:0] cnt;
  logic             leading;
  logic             hit;

  function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] w, input logic lead);
    return lead ? (w << 1) : (w >> 1);
  endfunction

  assign leading = ~op_q[1];
  assign hit     = leading ? work[WIDTH-1] : work[0];
  assign busy    = (state == SCAN_RUN) || (state == SCAN_DONE);
  assign done    = (state == SCAN_DONE);

  // Control state and architecturally visible results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SCAN_IDLE;
      count      <= '0;
      normalized <= '0;
    end else begin
      case (state)
        SCAN_IDLE: if (start) state <= SCAN_LOAD;
        SCAN_LOAD: state <= SCAN_RUN;
        SCAN_RUN: begin
          if (work == '0) begin
            count      <= FULL_CNT;
            normalized <= '0;
            state      <= SCAN_DONE;
          end else if (hit) begin
            count      <= cnt;
            normalized <= leading ? (opnd_q << cnt) : (opnd_q >> cnt);
            state      <= SCAN_DONE;
          end
        end
        SCAN_DONE: state <= SCAN_IDLE;
        default:   state <= SCAN_IDLE;
      endcase
    end
  end

  // Scan datapath; its contents are meaningless outside an active request.
  always_ff @(posedge clk) begin
    case (state)
      SCAN_IDLE: begin
        if (start) begin
          op_q   <= scan_op;
          opnd_q <= operand;
        end
      end
      SCAN_LOAD: begin
        work <= op_q[0] ? ~opnd_q : opnd_q;
        cnt  <= '0;
      end
      SCAN_RUN: begin
        if (work != '0 && !hit) begin
          work <= shift_once(work, leading);
          cnt  <= cnt + 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_seq_bit_scanner.sv
// Directed bench for seq_bit_scanner: results, latency, busy span, ignored starts and reset abort.
module tb_seq_bit_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  scan_op;
  logic [31:0] operand;
  logic        busy;
  logic        done;
  logic [5:0]  count;
  logic [31:0] normalized;

  int n_checks = 0;
  int n_errors = 0;

  seq_bit_scanner #(.WIDTH(32), .CNT_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .scan_op    (scan_op),
    .operand    (operand),
    .busy       (busy),
    .done       (done),
    .count      (count),
    .normalized (normalized)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request and track it until done; optionally poke a second start mid-scan.
  task automatic run_scan(input string tag, input logic [1:0] op, input logic [31:0] opnd,
                          input int exp_lat, input logic [5:0] exp_cnt,
                          input logic [31:0] exp_norm, input bit inject);
    int lat;
    int busy_cycles;
    lat = -1;
    busy_cycles = 0;
    @(negedge clk);
    start   = 1'b1;
    scan_op = op;
    operand = opnd;
    @(posedge clk);
    #1;
    start   = 1'b0;
    scan_op = ~op;
    operand = ~opnd;
    for (int i = 1; i <= 80; i++) begin
      @(posedge clk);
      #1;
      if (inject && i == 3) begin
        start   = 1'b1;
        scan_op = 2'b00;
        operand = 32'h8000_0000;
      end else begin
        start = 1'b0;
      end
      if (busy) busy_cycles++;
      if (done) begin
        lat = i;
        break;
      end
    end
    start = 1'b0;
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_busy_cycles"}, 64'(busy_cycles), 64'(exp_lat));
    check({tag, "_count"}, 64'(count), 64'(exp_cnt));
    check({tag, "_normalized"}, 64'(normalized), 64'(exp_norm));
    @(posedge clk);
    #1;
    check({tag, "_done_single"}, 64'(done), 64'd0);
    check({tag, "_busy_clear"}, 64'(busy), 64'd0);
    check({tag, "_count_hold"}, 64'(count), 64'(exp_cnt));
  endtask

  initial begin
    int seen_done;
    rst = 1'b1;
    start = 1'b0;
    scan_op = 2'b00;
    operand = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_norm", 64'(normalized), 64'd0);
    rst = 1'b0;

    run_scan("clz_10000", 2'b00, 32'h0001_0000, 17, 6'd15, 32'h8000_0000, 1'b0);
    run_scan("clo_fff12345", 2'b01, 32'hFFF1_2345, 14, 6'd12, 32'h1234_5000, 1'b0);
    run_scan("ctz_a00", 2'b10, 32'h0000_0A00, 11, 6'd9, 32'h0000_0005, 1'b0);
    run_scan("cto_b", 2'b11, 32'h0000_000B, 4, 6'd2, 32'h0000_0002, 1'b0);
    run_scan("clz_zero", 2'b00, 32'h0000_0000, 2, 6'd32, 32'h0000_0000, 1'b0);
    run_scan("cto_ones", 2'b11, 32'hFFFF_FFFF, 2, 6'd32, 32'h0000_0000, 1'b0);
    run_scan("clz_one_ign", 2'b00, 32'h0000_0001, 33, 6'd31, 32'h8000_0000, 1'b1);
    run_scan("clz_msb", 2'b00, 32'h8000_0000, 2, 6'd0, 32'h8000_0000, 1'b0);
    run_scan("clo_again", 2'b01, 32'hFFF1_2345, 14, 6'd12, 32'h1234_5000, 1'b0);

    // Abort a long scan with reset and make sure it never completes.
    @(negedge clk);
    start   = 1'b1;
    scan_op = 2'b00;
    operand = 32'h0000_0001;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("abort_busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_count", 64'(count), 64'd0);
    check("abort_norm", 64'(normalized), 64'd0);
    seen_done = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) seen_done++;
    end
    check("abort_no_done", 64'(seen_done), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
